// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a small W-bit ALU.
// Each accepted operation passes IDLE -> EXEC -> RESP and is held until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         ptr;
  logic         grant0, grant1;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         id_q;
  logic [W-1:0] alu_y;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant0 = !ptr;
          grant1 = ptr;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are forced low during reset even though the state already reads IDLE.
  assign req0_ready = grant0 && rst_n;
  assign req1_ready = grant1 && rst_n;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    alu_y = '0;
    case (op_q)
      3'b001:  alu_y = a_q + b_q;
      3'b010:  alu_y = a_q - b_q;
      3'b011:  alu_y = a_q & b_q;
      3'b100:  alu_y = a_q | b_q;
      3'b101:  alu_y = ~a_q;
      3'b110:  alu_y = ~b_q;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (state == IDLE && (grant0 || grant1)) begin
      op_q <= grant1 ? req1_op : req0_op;
      a_q  <= grant1 ? req1_a  : req0_a;
      b_q  <= grant1 ? req1_b  : req0_b;
      id_q <= grant1;
      ptr  <= !ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= alu_y;
      rsp_id   <= id_q;
    end
  end

endmodule
